// File: rtl/pipe_stage_chain_if.sv
// Bundle between the pipeline chain, its producer (IF) and the hazard/branch controller.
// Payload width and stage count must match the pipe_stage_chain instance they connect to.
interface pipe_stage_chain_if #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
);

  logic                      in_valid;
  logic [WIDTH-1:0]          in_data;
  logic                      in_ready;
  logic [STAGES-1:0]         stall_req;
  logic [STAGES-1:0]         flush_req;
  logic [STAGES-1:0]         stage_valid;
  logic [STAGES*WIDTH-1:0]   stage_data;
  logic [31:0]               perf_stall_cnt;
  logic [31:0]               perf_flush_cnt;
  logic [31:0]               perf_bubble_cnt;

  // Producer plus hazard controller side.
  modport master (
    output in_valid, in_data, stall_req, flush_req,
    input  in_ready, stage_valid, stage_data,
           perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt
  );

  // Pipeline chain side.
  modport slave (
    input  in_valid, in_data, stall_req, flush_req,
    output in_ready, stage_valid, stage_data,
           perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt
  );

endinterface

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline registers with per-stage valid bits,
// stall back-pressure toward younger stages and age-ordered flush.
// Stage 0 is youngest, stage STAGES-1 oldest.
// Optional performance counters are enabled by defining PIPE_STAGE_CHAIN_PERF_EN;
// without it the perf ports read 0 and no counter flops exist.
module pipe_stage_chain #(
  parameter int unsigned      WIDTH       = 64,
  parameter int unsigned      STAGES      = 4,
  parameter logic [WIDTH-1:0] NOP_PAYLOAD = '0
) (
  input logic               clk,
  input logic               rst,
  pipe_stage_chain_if.slave bus
);

  localparam int unsigned CNT_W = 32;

  logic [STAGES-1:0]             valid_q;
  logic [STAGES-1:0]             valid_d;
  logic [STAGES-1:0][WIDTH-1:0]  data_q;
  logic [STAGES-1:0][WIDTH-1:0]  data_d;
  logic [STAGES-1:0]             hold;
  logic [STAGES-1:0]             kill;
  logic                          hold_acc;
  logic                          kill_acc;

  // A stall or flush at stage j reaches every younger stage i <= j.
  always_comb begin
    hold     = '0;
    kill     = '0;
    hold_acc = 1'b0;
    kill_acc = 1'b0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      hold_acc = hold_acc | bus.stall_req[i];
      kill_acc = kill_acc | bus.flush_req[i];
      hold[i]  = hold_acc;
      kill[i]  = kill_acc;
    end
  end

  // Next stage contents: flush beats stall; a stalled upstream feeds a bubble downstream.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (kill[0]) begin
      valid_d[0] = 1'b0;
      data_d[0]  = NOP_PAYLOAD;
    end else if (!hold[0]) begin
      valid_d[0] = bus.in_valid;
      data_d[0]  = bus.in_valid ? bus.in_data : NOP_PAYLOAD;
    end
    for (int unsigned i = 1; i < STAGES; i++) begin
      if (kill[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = NOP_PAYLOAD;
      end else if (hold[i]) begin
        valid_d[i] = valid_q[i];
        data_d[i]  = data_q[i];
      end else if (hold[i-1]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = NOP_PAYLOAD;
      end else begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end
  end

  // Stage registers with synchronous reset to empty NOP stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= {STAGES{NOP_PAYLOAD}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Stage 0 takes the producer payload only when it neither holds nor is flushed.
  assign bus.in_ready    = !hold[0] && !kill[0] && !rst;
  assign bus.stage_valid = valid_q;
  assign bus.stage_data  = data_q;

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic             stall_event;
  logic             flush_event;
  logic             bubble_event;

  // A flush cycle is not counted as a stall cycle even if stalls are also requested.
  assign stall_event  = (|bus.stall_req) && !(|bus.flush_req);
  assign flush_event  = |bus.flush_req;
  assign bubble_event = !valid_q[STAGES-1];

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall_event && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_event && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (bubble_event && (bubble_cnt_q != {CNT_W{1'b1}}))
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign bus.perf_stall_cnt  = stall_cnt_q;
  assign bus.perf_flush_cnt  = flush_cnt_q;
  assign bus.perf_bubble_cnt = bubble_cnt_q;
`else
  assign bus.perf_stall_cnt  = '0;
  assign bus.perf_flush_cnt  = '0;
  assign bus.perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (WIDTH=8, STAGES=4, NOP=0).
// Reference model works from the highest stalled / flushed stage index.
module tb_pipe_stage_chain;

  localparam int unsigned W = 8;
  localparam int unsigned S = 4;

  logic clk;
  logic rst;

  pipe_stage_chain_if #(.WIDTH(W), .STAGES(S)) bus ();

  pipe_stage_chain #(.WIDTH(W), .STAGES(S), .NOP_PAYLOAD(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference state
  logic       mv [S];
  logic [7:0] md [S];
  logic [31:0] m_stall_cnt, m_flush_cnt, m_bubble_cnt;
  logic       got_ready, exp_ready;

  function automatic logic [S-1:0] exp_valid();
    logic [S-1:0] r;
    for (int i = 0; i < S; i++) r[i] = mv[i];
    return r;
  endfunction

  function automatic logic [S*W-1:0] exp_data();
    logic [S*W-1:0] r;
    for (int i = 0; i < S; i++) r[i*W +: W] = md[i];
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  // Drive one cycle, sample in_ready mid-cycle, advance the model at the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic [S-1:0] st,
                      input logic [S-1:0] fl, input logic r);
    int hs, hf;
    logic       nv [S];
    logic [7:0] nd [S];
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.stall_req = st;
    bus.flush_req = fl;
    rst           = r;
    #2;
    got_ready = bus.in_ready;
    hs = -1;
    hf = -1;
    for (int j = 0; j < S; j++) begin
      if (st[j]) hs = j;
      if (fl[j]) hf = j;
    end
    exp_ready = (hs < 0) && (hf < 0) && !r;
    @(posedge clk);
    if (r) begin
      m_stall_cnt = '0; m_flush_cnt = '0; m_bubble_cnt = '0;
    end else begin
      if (hs >= 0 && hf < 0) m_stall_cnt = sat_inc(m_stall_cnt);
      if (hf >= 0) m_flush_cnt = sat_inc(m_flush_cnt);
      if (!mv[S-1]) m_bubble_cnt = sat_inc(m_bubble_cnt);
    end
    for (int i = 0; i < S; i++) begin
      if (r || i <= hf) begin
        nv[i] = 1'b0; nd[i] = 8'h00;
      end else if (i <= hs) begin
        nv[i] = mv[i]; nd[i] = md[i];
      end else if (hs >= 0 && i == hs + 1) begin
        nv[i] = 1'b0; nd[i] = 8'h00;
      end else if (i == 0) begin
        nv[i] = v; nd[i] = v ? d : 8'h00;
      end else begin
        nv[i] = mv[i-1]; nd[i] = md[i-1];
      end
    end
    for (int i = 0; i < S; i++) begin
      mv[i] = nv[i]; md[i] = nd[i];
    end
    #1;
  endtask

  task automatic load_1144();
    step(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b1);
    step(1'b1, 8'h11, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 8'h22, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 8'h33, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 8'h44, 4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < S; i++) begin mv[i] = 1'bx; md[i] = 8'hxx; end
    step(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b1);
    step(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b1);
    n_tests++;
    if (bus.stage_valid !== 4'b0000 || bus.stage_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: valid=%b data=%h required valid=0000 data=0", bus.stage_valid, bus.stage_data);
    end
    n_tests++;
    if (got_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b required 0", got_ready);
    end
  endtask

  task automatic test_flow();
    load_1144();
    n_tests++;
    if (bus.stage_valid !== 4'b1111 || bus.stage_data !== 32'h11223344) begin
      n_fail++;
      $display("FAIL flow: valid=%b data=%h required 1111 11223344", bus.stage_valid, bus.stage_data);
    end
    n_tests++;
    if (got_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flow_ready: in_ready=%b required 1", got_ready);
    end
  endtask

  task automatic test_mid_stall();
    load_1144();
    step(1'b1, 8'h55, 4'b0010, 4'b0000, 1'b0);
    n_tests++;
    if (bus.stage_valid !== 4'b1011 || bus.stage_data !== 32'h22003344 || got_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_c1: valid=%b data=%h rdy=%b required 1011 22003344 0", bus.stage_valid, bus.stage_data, got_ready);
    end
    step(1'b1, 8'h55, 4'b0010, 4'b0000, 1'b0);
    n_tests++;
    if (bus.stage_valid !== 4'b0011 || bus.stage_data !== 32'h00003344 || got_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_c2: valid=%b data=%h rdy=%b required 0011 00003344 0", bus.stage_valid, bus.stage_data, got_ready);
    end
    step(1'b1, 8'h55, 4'b0000, 4'b0000, 1'b0);
    n_tests++;
    if (bus.stage_valid !== 4'b0111 || bus.stage_data !== 32'h00334455 || got_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: valid=%b data=%h rdy=%b required 0111 00334455 1", bus.stage_valid, bus.stage_data, got_ready);
    end
  endtask

  task automatic test_flush();
    load_1144();
    step(1'b1, 8'h66, 4'b0000, 4'b0100, 1'b0);
    n_tests++;
    if (bus.stage_valid !== 4'b1000 || bus.stage_data !== 32'h22000000 || got_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: valid=%b data=%h rdy=%b required 1000 22000000 0", bus.stage_valid, bus.stage_data, got_ready);
    end
  endtask

  task automatic test_flush_stall();
    load_1144();
    step(1'b1, 8'h99, 4'b1000, 4'b0010, 1'b0);
    n_tests++;
    if (bus.stage_valid !== 4'b1100 || bus.stage_data !== 32'h11220000 || got_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall: valid=%b data=%h rdy=%b required 1100 11220000 0", bus.stage_valid, bus.stage_data, got_ready);
    end
  endtask

  task automatic test_reset_mid();
    load_1144();
    step(1'b1, 8'h77, 4'b0001, 4'b0000, 1'b1);
    n_tests++;
    if (bus.stage_valid !== 4'b0000 || bus.stage_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b data=%h required 0000 0", bus.stage_valid, bus.stage_data);
    end
    step(1'b1, 8'h77, 4'b0000, 4'b0000, 1'b0);
    n_tests++;
    if (bus.stage_valid !== 4'b0001 || bus.stage_data !== 32'h00000077 || got_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b data=%h rdy=%b required 0001 00000077 1", bus.stage_valid, bus.stage_data, got_ready);
    end
  endtask

  task automatic test_random();
    logic [S-1:0] st, fl;
    for (int c = 0; c < 400; c++) begin
      st = ($urandom_range(0, 3) == 0) ? S'($urandom) : '0;
      fl = ($urandom_range(0, 5) == 0) ? S'($urandom) : '0;
      step(1'($urandom), 8'($urandom), st, fl, ($urandom_range(0, 60) == 0));
      n_tests++;
      if (bus.stage_valid !== exp_valid() || bus.stage_data !== exp_data() || got_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL random[%0d]: valid=%b data=%h rdy=%b required %b %h %b", c,
                 bus.stage_valid, bus.stage_data, got_ready, exp_valid(), exp_data(), exp_ready);
      end
    end
  endtask

  task automatic test_perf();
    step(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b1);
    for (int c = 0; c < 3; c++) step(1'b0, 8'h00, 4'b0100, 4'b0000, 1'b0);
    step(1'b0, 8'h00, 4'b0001, 4'b0010, 1'b0);
    for (int c = 0; c < 5; c++) step(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    n_tests++;
    if (bus.perf_stall_cnt !== 32'd3 || bus.perf_flush_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL perf_sf: stall=%0d flush=%0d required 3 1", bus.perf_stall_cnt, bus.perf_flush_cnt);
    end
    n_tests++;
    if (bus.perf_bubble_cnt !== m_bubble_cnt || bus.perf_bubble_cnt < 32'd5) begin
      n_fail++;
      $display("FAIL perf_bubble: bubble=%0d required %0d", bus.perf_bubble_cnt, m_bubble_cnt);
    end
    test_random();
    n_tests++;
    if (bus.perf_stall_cnt !== m_stall_cnt || bus.perf_flush_cnt !== m_flush_cnt ||
        bus.perf_bubble_cnt !== m_bubble_cnt) begin
      n_fail++;
      $display("FAIL perf_random: %0d %0d %0d required %0d %0d %0d", bus.perf_stall_cnt,
               bus.perf_flush_cnt, bus.perf_bubble_cnt, m_stall_cnt, m_flush_cnt, m_bubble_cnt);
    end
`else
    n_tests++;
    if (bus.perf_stall_cnt !== 32'd0 || bus.perf_flush_cnt !== 32'd0 || bus.perf_bubble_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_off: %0d %0d %0d required 0 0 0", bus.perf_stall_cnt,
               bus.perf_flush_cnt, bus.perf_bubble_cnt);
    end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_stall_cnt = '0; m_flush_cnt = '0; m_bubble_cnt = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.stall_req = '0;
    bus.flush_req = '0;
    rst = 1'b1;
    test_reset();
    test_flow();
    test_mid_stall();
    test_flush();
    test_flush_stall();
    test_reset_mid();
    test_random();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
